// File: rtl/quadrature_step_generator_pkg.sv
// Shared types and helpers for the quadrature step generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - step sequencer states (IDLE, P1, P2, P3, GAP)
//   LINES_IDLE     - {A,B} rest level, both lines high
//   LINES_BOTH_LOW - {A,B} mid-detent level, both lines low
//   lines()        - {A,B} line pattern for a given state and direction
//   max_int()      - larger of two ints, used for timer sizing
package quad_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [1:0] LINES_IDLE     = 2'b11;
    localparam logic [1:0] LINES_BOTH_LOW = 2'b00;

    // {A,B} for each state. Right steps let A lead (A falls first), left
    // steps let B lead. The sequence 11 -> x -> 00 -> y -> 11 is Gray coded,
    // so only one line moves on any state change.
    function automatic logic [1:0] lines(input state_t st, input logic dir_left);
        logic [1:0] ab;
        ab = LINES_IDLE;
        case (st)
            P1:      ab = dir_left ? 2'b10 : 2'b01;
            P2:      ab = LINES_BOTH_LOW;
            P3:      ab = dir_left ? 2'b01 : 2'b10;
            default: ab = LINES_IDLE;
        endcase
        return ab;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/quadrature_step_generator_step_fifo.sv
// Small synchronous FIFO holding one direction bit per queued step.
// Latency: a pushed entry is visible at pop_dat (empty=0) the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; full/count are registered.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push_vld, push_dat  - write request and data bit
//   pop_rdy, pop_dat    - read request and head-of-queue data bit
//   full, empty, count  - occupancy status (count is $clog2(DEPTH)+1 bits)
module step_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic                     push_dat,
    input  logic                     pop_rdy,
    output logic                     pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/quadrature_step_generator.sv
// Turns queued step requests into one full A/B quadrature detent cycle per step.
// Latency: request accepted at edge t (idle, queue empty) -> first line edge at t+2.
// Backpressure: step_ready drops while the DEPTH-entry request queue is full.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   step_valid, step_left   - step request and its direction (1=left, 0=right)
//   step_ready              - request queue can accept
//   quad_a, quad_b          - registered quadrature lines, rest at 1/1
//   busy                    - sequencer active or requests queued (registered)
//   step_done               - one-cycle pulse as the lines return to 1/1
//   pending                 - request queue occupancy
module quadrature_step_generator
    import quad_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 1000,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_valid,
    input  logic                   step_left,
    output logic                   step_ready,
    output logic                   quad_a,
    output logic                   quad_b,
    output logic                   busy,
    output logic                   step_done,
    output logic [$clog2(DEPTH):0] pending
);

    // Timer only ever holds a reload value minus something, so max-1 must fit.
    localparam int TMAX = max_int(PHASE_CYCLES, GAP_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dir_q, dir_d;
    logic          timer_zero;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;

    logic [1:0]    lines_d, lines_q;
    logic          done_d, done_q;
    logic          busy_d, busy_q;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign step_ready = !fifo_full;
    assign fifo_push  = step_valid && step_ready;

    step_fifo #(
        .DEPTH (DEPTH)
    ) u_step_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (fifo_push),
        .push_dat (step_left),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (pending)
    );

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    dir_d    = fifo_dat;
                    state_d  = P1;
                    timer_d  = PHASE_LOAD;
                end
            end
            P1: begin
                if (timer_zero) begin
                    state_d = P2;
                    timer_d = PHASE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            P2: begin
                if (timer_zero) begin
                    state_d = P3;
                    timer_d = PHASE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            P3: begin
                if (timer_zero) begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: outputs
    // ------------------------------------------------------------------
    // The first GAP cycle is the one where the lines are about to return
    // to rest; flagging it here makes step_done coincide with that edge
    // once both go through the output register.
    always_comb begin
        lines_d = lines(state_q, dir_q);
        done_d  = (state_q == GAP) && (timer_q == GAP_LOAD);
        busy_d  = (state_q != IDLE) || !fifo_empty;
    end

    // Registered outputs keep the lines glitch-free for the wheel input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_q <= LINES_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lines_q <= lines_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign quad_a    = lines_q[1];
    assign quad_b    = lines_q[0];
    assign step_done = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
module tb_quadrature_step_generator;

    localparam int P        = 4;
    localparam int G        = 3;
    localparam int D        = 4;
    localparam int STEP_LEN = 3 * P + G;

    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b1;
    logic                 step_valid = 1'b0;
    logic                 step_left  = 1'b0;
    logic                 step_ready;
    logic                 quad_a;
    logic                 quad_b;
    logic                 busy;
    logic                 step_done;
    logic [$clog2(D):0]   pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Observed trace
    int         edge_cyc[$];
    logic [1:0] edge_ab[$];
    int         done_cyc[$];
    int         busy_fall[$];
    int         dbl = 0;
    logic [1:0] prev_ab   = 2'b11;
    logic       prev_busy = 1'b0;

    // Reference model: accept edge, direction and pop edge of each step
    int   m_acc[$];
    logic m_dir[$];
    int   m_start[$];

    quadrature_step_generator #(
        .PHASE_CYCLES (P),
        .GAP_CYCLES   (G),
        .DEPTH        (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_valid (step_valid),
        .step_left  (step_left),
        .step_ready (step_ready),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .busy       (busy),
        .step_done  (step_done),
        .pending    (pending)
    );

    always #15 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line/flag monitor sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ab   = 2'b11;
            prev_busy = 1'b0;
        end else begin
            if ({quad_a, quad_b} !== prev_ab) begin
                if (quad_a !== prev_ab[1] && quad_b !== prev_ab[0]) dbl++;
                edge_cyc.push_back(cyc);
                edge_ab.push_back({quad_a, quad_b});
                prev_ab = {quad_a, quad_b};
            end
            if (step_done === 1'b1) done_cyc.push_back(cyc);
            if (prev_busy && !busy) busy_fall.push_back(cyc);
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {A,B} after the j-th line edge of a step
    function automatic logic [1:0] expected_ab(input logic left, input int j);
        logic [1:0] r [4];
        logic [1:0] l [4];
        r = '{2'b01, 2'b00, 2'b10, 2'b11};
        l = '{2'b10, 2'b00, 2'b01, 2'b11};
        return left ? l[j] : r[j];
    endfunction

    task automatic clear_trace();
        edge_cyc.delete();
        edge_ab.delete();
        done_cyc.delete();
        busy_fall.delete();
        dbl = 0;
        m_acc.delete();
        m_dir.delete();
        m_start.delete();
    endtask

    // Offer one request, hold it until accepted, and extend the model.
    task automatic push_step(input logic left);
        int exp_pend;
        int t;
        int s;
        int waited;
        waited = 0;
        @(negedge clk);
        step_valid = 1'b1;
        step_left  = left;
        forever begin
            exp_pend = m_acc.size();
            foreach (m_start[i]) if (m_start[i] <= cyc) exp_pend--;
            checks++;
            if (step_ready !== (exp_pend != D)) begin
                failures++;
                $display("FAIL push_ready: got %b want %b at cycle %0d", step_ready, (exp_pend != D), cyc);
            end
            checks++;
            if (int'(pending) != exp_pend) begin
                failures++;
                $display("FAIL push_pending: got %0d want %0d at cycle %0d", pending, exp_pend, cyc);
            end
            if (step_ready === 1'b1) break;
            waited++;
            if (waited > 100) begin
                failures++;
                $display("FAIL push_timeout: request not accepted within 100 cycles");
                step_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        t = cyc + 1;
        @(posedge clk);
        s = t + 1;
        if (m_start.size() > 0 && m_start[$] + STEP_LEN + 1 > s) s = m_start[$] + STEP_LEN + 1;
        m_acc.push_back(t);
        m_dir.push_back(left);
        m_start.push_back(s);
        #2;
        step_valid = 1'b0;
        step_left  = 1'($urandom);
    endtask

    task automatic wait_model_done();
        int limit;
        limit = m_start[$] + STEP_LEN + 4;
        while (cyc < limit) @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #5;
        checks++; if (quad_a !== 1'b1) begin failures++; $display("FAIL reset_a: got %b want 1", quad_a); end
        checks++; if (quad_b !== 1'b1) begin failures++; $display("FAIL reset_b: got %b want 1", quad_b); end
        checks++; if (step_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", step_ready); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending: got %0d want 0", pending); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", step_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_trace();
        repeat (20) @(posedge clk);
        #3;
        checks++; if (edge_cyc.size() != 0) begin failures++; $display("FAIL idle_edges: got %0d want 0", edge_cyc.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if ({quad_a, quad_b} !== 2'b11) begin failures++; $display("FAIL idle_lines: got %b want 11", {quad_a, quad_b}); end
    endtask

    task automatic test_single_step(input logic left);
        int t;
        clear_trace();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        push_step(left);
        t = m_acc[0];
        checks++; if (pending !== 1) begin failures++; $display("FAIL single_pending: got %0d want 1", pending); end
        repeat (STEP_LEN + 8) @(posedge clk);
        #3;
        checks++;
        if (edge_cyc.size() != 4) begin failures++; $display("FAIL single_edge_count dir=%b: got %0d want 4", left, edge_cyc.size()); end
        for (int j = 0; j < 4 && j < edge_cyc.size(); j++) begin
            checks++;
            if (edge_cyc[j] != t + 2 + j * P || edge_ab[j] !== expected_ab(left, j)) begin
                failures++;
                $display("FAIL single_edge%0d dir=%b: got cyc %0d ab %b want cyc %0d ab %b",
                         j, left, edge_cyc[j], edge_ab[j], t + 2 + j * P, expected_ab(left, j));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t + 2 + 3 * P) begin
            failures++;
            $display("FAIL single_done dir=%b: got %0d pulses first %0d want 1 at %0d",
                     left, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 2 + 3 * P);
        end
        checks++;
        if (busy_fall.size() != 1 || busy_fall[0] != t + 2 + STEP_LEN) begin
            failures++;
            $display("FAIL single_busy_fall dir=%b: got %0d falls first %0d want 1 at %0d",
                     left, busy_fall.size(), (busy_fall.size() > 0) ? busy_fall[0] : -1, t + 2 + STEP_LEN);
        end
        checks++; if (dbl != 0) begin failures++; $display("FAIL single_one_toggle: got %0d double toggles want 0", dbl); end
    endtask

    task automatic test_fifo_fill();
        logic dirs [7];
        int   n;
        dirs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dirs[5] = 1'($urandom);
        dirs[6] = 1'($urandom);
        clear_trace();
        for (int i = 0; i < 7; i++) push_step(dirs[i]);
        wait_model_done();
        n = m_start.size();
        checks++;
        if (edge_cyc.size() != 4 * n) begin failures++; $display("FAIL fill_edge_count: got %0d want %0d", edge_cyc.size(), 4 * n); end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < edge_cyc.size()) begin
                    checks++;
                    if (edge_cyc[4*k+j] != m_start[k] + 1 + j * P || edge_ab[4*k+j] !== expected_ab(m_dir[k], j)) begin
                        failures++;
                        $display("FAIL fill_edge step%0d/%0d: got cyc %0d ab %b want cyc %0d ab %b", k, j,
                                 edge_cyc[4*k+j], edge_ab[4*k+j], m_start[k] + 1 + j * P, expected_ab(m_dir[k], j));
                    end
                end
            end
        end
        checks++;
        if (done_cyc.size() != n) begin failures++; $display("FAIL fill_done_count: got %0d want %0d", done_cyc.size(), n); end
        for (int k = 0; k < n && k < done_cyc.size(); k++) begin
            checks++;
            if (done_cyc[k] != m_start[k] + 1 + 3 * P) begin
                failures++;
                $display("FAIL fill_done%0d: got %0d want %0d", k, done_cyc[k], m_start[k] + 1 + 3 * P);
            end
        end
        checks++; if (dbl != 0) begin failures++; $display("FAIL fill_one_toggle: got %0d want 0", dbl); end
        checks++; if (pending !== '0 || busy !== 1'b0) begin failures++; $display("FAIL fill_drain: got pending %0d busy %b want 0 0", pending, busy); end
    endtask

    task automatic test_reset_mid_step();
        int target;
        clear_trace();
        for (int i = 0; i < 3; i++) push_step(1'($urandom));
        target = m_start[0] + P + 1;
        while (cyc < target) begin
            @(posedge clk);
            #3;
        end
        checks++; if ({quad_a, quad_b} !== 2'b00) begin failures++; $display("FAIL midrst_p2_lines: got %b want 00", {quad_a, quad_b}); end
        checks++; if (pending !== 2) begin failures++; $display("FAIL midrst_pending_before: got %0d want 2", pending); end
        #5 rst_n = 1'b0;
        #1;
        checks++; if ({quad_a, quad_b} !== 2'b11) begin failures++; $display("FAIL midrst_lines: got %b want 11", {quad_a, quad_b}); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL midrst_pending: got %0d want 0", pending); end
        checks++; if (step_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_flags: got ready %b busy %b want 1 0", step_ready, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_trace();
        repeat (40) @(posedge clk);
        #3;
        checks++; if (edge_cyc.size() != 0) begin failures++; $display("FAIL midrst_no_edges: got %0d want 0", edge_cyc.size()); end
        checks++; if (done_cyc.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_quiet: got done %0d busy %b want 0 0", done_cyc.size(), busy); end
    endtask

    // Behavioural wheel decoder on the recorded line edges: the first move
    // away from 11 tells the direction (A first = right, B first = left).
    task automatic test_loopback();
        logic got[$];
        logic at_rest;
        clear_trace();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            push_step(i >= 3);
        end
        wait_model_done();
        at_rest = 1'b1;
        foreach (edge_ab[i]) begin
            if (at_rest) begin
                if (edge_ab[i] == 2'b01) got.push_back(1'b0);
                else if (edge_ab[i] == 2'b10) got.push_back(1'b1);
                at_rest = 1'b0;
            end
            if (edge_ab[i] == 2'b11) at_rest = 1'b1;
        end
        checks++;
        if (got.size() != 5) begin failures++; $display("FAIL loop_event_count: got %0d want 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== (i >= 3)) begin failures++; $display("FAIL loop_dir%0d: got %b want %b", i, got[i], (i >= 3)); end
        end
        checks++; if (done_cyc.size() != 5) begin failures++; $display("FAIL loop_done_count: got %0d want 5", done_cyc.size()); end
        checks++; if (dbl != 0) begin failures++; $display("FAIL loop_one_toggle: got %0d want 0", dbl); end
    endtask

    initial begin
        test_reset();
        test_single_step(1'b0);
        test_single_step(1'b1);
        test_fifo_fill();
        test_reset_mid_step();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
